// File: rtl/alu_pkg.sv
// Shared types and constants for the UART ALU command path.
// The response serializer is expected to reuse this package.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_DIV = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    OPND  = 2'd1,
    EMIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [7:0]  OpcAdd    = 8'hAD;
  localparam logic [7:0]  OpcMul    = 8'h63;
  localparam logic [7:0]  OpcDiv    = 8'h5B;
  localparam int unsigned HdrBytes  = 4;
  localparam int unsigned WordBytes = 4;
  localparam logic [15:0] MinLen    = 16'd12;
  localparam logic [15:0] DivLen    = 16'd12;

  // Map a raw opcode byte onto the ALU operation; unknown bytes map to add
  // but are rejected by hdr_valid before they can be used.
  function automatic op_e opc_to_op(input logic [7:0] opc);
    op_e op;
    case (opc)
      OpcMul:  op = OP_MUL;
      OpcDiv:  op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  // A header is accepted only for a known opcode with a word-aligned length
  // inside [MinLen, max_len]; divide always carries exactly two operands.
  function automatic logic hdr_valid(input logic [7:0]  opc,
                                     input logic [15:0] len,
                                     input logic [15:0] max_len);
    logic known;
    known = (opc == OpcAdd) || (opc == OpcMul) || (opc == OpcDiv);
    return known && (len[1:0] == 2'b00) && (len >= MinLen) && (len <= max_len)
           && ((opc != OpcDiv) || (len == DivLen));
  endfunction

endpackage

// File: rtl/alu_cmd_parser.sv
// Receive-side command decoder: parses the 4-byte header from the UART byte
// stream, assembles little-endian 32-bit operands for the ALU core and
// discards the payload of malformed commands so framing is preserved.
module alu_cmd_parser
  import alu_pkg::*;
#(
  parameter logic [15:0] MaxLen = 16'd1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_tdata_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o,
  output op_e         op_o,
  output logic [31:0] operand_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        operand_first_o,
  output logic        operand_last_o,
  output logic        err_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [7:0]  hdr_b0_q, hdr_b0_d;
  logic [7:0]  hdr_b2_q, hdr_b2_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] operand_q, operand_d;
  op_e         op_q, op_d;
  logic [13:0] n_q, n_d;
  logic [13:0] idx_q, idx_d;
  logic [15:0] drain_q, drain_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic        hs_s;
  logic [15:0] len_s;
  logic [15:0] len_m4_s;
  logic        hdr_ok_s;

  // Length is completed by the incoming 4th header byte (high byte).
  assign hs_s     = rx_tvalid_i & rdy_q;
  assign len_s    = {rx_tdata_i, hdr_b2_q};
  assign len_m4_s = (len_s >= 16'd4) ? (len_s - 16'd4) : 16'd0;
  assign hdr_ok_s = hdr_valid(hdr_b0_q, len_s, MaxLen);

  // Next-state logic for the header/operand/emit/drain FSM and its datapath.
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    hdr_b0_d   = hdr_b0_q;
    hdr_b2_d   = hdr_b2_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    operand_d  = operand_q;
    op_d       = op_q;
    n_d        = n_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    valid_d    = valid_q;
    first_d    = first_q;
    last_d     = last_q;
    err_d      = 1'b0;

    case (state_q)
      HDR: begin
        if (hs_s) begin
          case (hdr_cnt_q)
            2'd0:    hdr_b0_d = rx_tdata_i;
            2'd2:    hdr_b2_d = rx_tdata_i;
            default: hdr_b0_d = hdr_b0_q;
          endcase
          if (hdr_cnt_q == 2'(HdrBytes - 1)) begin
            hdr_cnt_d = 2'd0;
            if (hdr_ok_s) begin
              op_d       = opc_to_op(hdr_b0_q);
              n_d        = len_m4_s[15:2];
              idx_d      = 14'd0;
              byte_cnt_d = 2'd0;
              state_d    = OPND;
            end else begin
              err_d   = 1'b1;
              drain_d = len_m4_s;
              state_d = (len_m4_s != 16'd0) ? DRAIN : HDR;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
          end
        end else begin
          hdr_cnt_d = hdr_cnt_q;
        end
      end
      OPND: begin
        if (hs_s) begin
          // Bytes arrive LSB first, so shift right and enter at the top.
          shift_d = {rx_tdata_i, shift_q[23:8]};
          if (byte_cnt_q == 2'(WordBytes - 1)) begin
            operand_d  = {rx_tdata_i, shift_q};
            valid_d    = 1'b1;
            first_d    = (idx_q == 14'd0);
            last_d     = (idx_q == (n_q - 14'd1));
            byte_cnt_d = 2'd0;
            state_d    = EMIT;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      EMIT: begin
        if (valid_q && operand_ready_i) begin
          valid_d = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = HDR;
          end else begin
            idx_d   = idx_q + 14'd1;
            state_d = OPND;
          end
        end else begin
          valid_d = valid_q;
        end
      end
      DRAIN: begin
        if (hs_s) begin
          drain_d = drain_q - 16'd1;
          state_d = (drain_q == 16'd1) ? HDR : DRAIN;
        end else begin
          drain_d = drain_q;
        end
      end
      default: begin
        state_d = HDR;
      end
    endcase

    // Outputs are registered, so they are computed from the next state.
    rdy_d  = (state_d != EMIT);
    busy_d = (state_d != HDR) || (hdr_cnt_d != 2'd0);
  end

  // State, datapath and registered-output flops; reset aborts any command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= HDR;
      hdr_cnt_q  <= 2'd0;
      hdr_b0_q   <= 8'd0;
      hdr_b2_q   <= 8'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      operand_q  <= 32'd0;
      op_q       <= OP_ADD;
      n_q        <= 14'd0;
      idx_q      <= 14'd0;
      drain_q    <= 16'd0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      hdr_b0_q   <= hdr_b0_d;
      hdr_b2_q   <= hdr_b2_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      operand_q  <= operand_d;
      op_q       <= op_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_tready_o     = rdy_q;
  assign op_o            = op_q;
  assign operand_o       = operand_q;
  assign operand_valid_o = valid_q;
  assign operand_first_o = first_q;
  assign operand_last_o  = last_q;
  assign err_o           = err_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Scoreboard bench for alu_cmd_parser: expected words are queued as operand
// bytes are driven and popped when the parser hands a word to the ALU side.
module tb_alu_cmd_parser;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready_o;
  op_e         op_o;
  logic [31:0] operand_o;
  logic        operand_valid_o;
  logic        operand_ready;
  logic        operand_first_o;
  logic        operand_last_o;
  logic        err_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int pops     = 0;

  // {op[1:0], data[31:0], first, last}
  logic [35:0] exp_q[$];

  logic        hold_v;
  logic [35:0] hold_w;

  alu_cmd_parser #(.MaxLen(16'd1024)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rx_tdata_i      (rx_tdata),
    .rx_tvalid_i     (rx_tvalid),
    .rx_tready_o     (rx_tready_o),
    .op_o            (op_o),
    .operand_o       (operand_o),
    .operand_valid_o (operand_valid_o),
    .operand_ready_i (operand_ready),
    .operand_first_o (operand_first_o),
    .operand_last_o  (operand_last_o),
    .err_o           (err_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: pops on each word handshake and checks hold-stability.
  always @(negedge clk) begin
    logic [35:0] e;
    logic [35:0] cur;
    cur = {op_o, operand_o, operand_first_o, operand_last_o};
    if (rst_n) begin
      if (err_o) err_cnt++;
      if (hold_v) begin
        n_checks++;
        if (!operand_valid_o || cur !== hold_w) begin
          n_fail++;
          $display("FAIL hold_stable got valid=%b word=%h required valid=1 word=%h",
                   operand_valid_o, cur, hold_w);
        end
      end
      if (operand_valid_o && operand_ready) begin
        n_checks++;
        pops++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_operand got word=%h required none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL operand_word got %h required %h (op,data,first,last)", cur, e);
          end
        end
      end
      hold_v = operand_valid_o && !operand_ready;
      hold_w = cur;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    while (!rx_tready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout got tready=0 required tready=1");
    end
    @(negedge clk);
    rx_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] opc, input logic [15:0] len);
    send_byte(opc);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic send_word(input op_e op, input logic [31:0] w,
                           input logic f, input logic l, input logic expect_it);
    if (expect_it) exp_q.push_back({op, w, f, l});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_tready_o, operand_valid_o, operand_first_o, operand_last_o, err_o, busy_o} !== 6'b0
        || operand_o !== 32'd0 || op_o !== OP_ADD) begin
      n_fail++;
      $display("FAIL reset_outputs got tready=%b valid=%b f=%b l=%b err=%b busy=%b data=%h op=%0d required all 0",
               rx_tready_o, operand_valid_o, operand_first_o, operand_last_o, err_o, busy_o,
               operand_o, op_o);
    end
    wait_cycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rx_tready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset got tready=%b busy=%b required tready=1 busy=0", rx_tready_o, busy_o);
    end
  endtask

  task automatic test_add;
    int e0, p0;
    e0 = err_cnt; p0 = pops;
    send_hdr(OpcAdd, 16'd16);
    n_checks++;
    if (busy_o !== 1'b1 || op_o !== OP_ADD) begin
      n_fail++;
      $display("FAIL add_hdr_latched got busy=%b op=%0d required busy=1 op=0", busy_o, op_o);
    end
    send_word(OP_ADD, 32'd1, 1'b1, 1'b0, 1'b1);
    send_word(OP_ADD, 32'd2, 1'b0, 1'b0, 1'b1);
    send_word(OP_ADD, 32'd3, 1'b0, 1'b1, 1'b1);
    wait_cycles(3);
    n_checks++;
    if (pops - p0 != 3 || err_cnt != e0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL add_cmd got words=%0d errs=%0d busy=%b required words=3 errs=0 busy=0",
               pops - p0, err_cnt - e0, busy_o);
    end
  endtask

  task automatic test_div_back_to_back;
    int e0, p0;
    e0 = err_cnt; p0 = pops;
    send_hdr(OpcDiv, 16'd12);
    send_word(OP_DIV, 32'd100, 1'b1, 1'b0, 1'b1);
    send_word(OP_DIV, 32'd7,   1'b0, 1'b1, 1'b1);
    // next header follows immediately, no idle gap
    send_hdr(OpcMul, 16'd12);
    send_word(OP_MUL, 32'h01020304, 1'b1, 1'b0, 1'b1);
    send_word(OP_MUL, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
    wait_cycles(3);
    n_checks++;
    if (pops - p0 != 4 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL div_back_to_back got words=%0d errs=%0d required words=4 errs=0",
               pops - p0, err_cnt - e0);
    end
  endtask

  task automatic drain_case(input logic [7:0] opc, input logic [15:0] len, input int nd);
    int e0, p0;
    e0 = err_cnt; p0 = pops;
    send_hdr(opc, len);
    send_junk(nd - 1);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_busy opc=%h len=%0d got busy=%b required 1 before last byte", opc, len, busy_o);
    end
    send_junk(1);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_done opc=%h len=%0d got busy=%b required 0 after %0d bytes", opc, len, busy_o, nd);
    end
    wait_cycles(2);
    n_checks++;
    if (err_cnt - e0 != 1 || pops != p0) begin
      n_fail++;
      $display("FAIL drain_err opc=%h len=%0d got errs=%0d words=%0d required errs=1 words=0",
               opc, len, err_cnt - e0, pops - p0);
    end
  endtask

  task automatic test_bad_opcode;
    int p0;
    drain_case(8'h12, 16'd12, 8);
    p0 = pops;
    send_hdr(OpcMul, 16'd12);
    send_word(OP_MUL, 32'd5, 1'b1, 1'b0, 1'b1);
    send_word(OP_MUL, 32'd6, 1'b0, 1'b1, 1'b1);
    wait_cycles(3);
    n_checks++;
    if (pops - p0 != 2) begin
      n_fail++;
      $display("FAIL mul_after_err got words=%0d required 2", pops - p0);
    end
  endtask

  task automatic test_div_bad_len;
    drain_case(OpcDiv, 16'd16, 12);
    drain_case(OpcAdd, 16'h000D, 9);
  endtask

  task automatic test_backpressure;
    int p0, bad;
    p0 = pops;
    bad = 0;
    send_hdr(OpcAdd, 16'd16);
    send_word(OP_ADD, 32'h0A0B0C0D, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    operand_ready = 1'b0;
    send_word(OP_ADD, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (rx_tready_o !== 1'b0 || operand_valid_o !== 1'b1 || operand_o !== 32'hDEADBEEF
          || operand_first_o !== 1'b0 || operand_last_o !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold got %0d bad cycles required 0", bad);
    end
    @(posedge clk);
    #1 operand_ready = 1'b1;
    wait_cycles(3);
    n_checks++;
    if (pops - p0 != 2 || operand_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_accept got words=%0d valid=%b required words=2 valid=0",
               pops - p0, operand_valid_o);
    end
    send_word(OP_ADD, 32'h12345678, 1'b0, 1'b1, 1'b1);
    wait_cycles(3);
  endtask

  task automatic test_reset_mid;
    int p0;
    send_hdr(OpcAdd, 16'd16);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_tready_o, operand_valid_o, operand_first_o, operand_last_o, err_o, busy_o} !== 6'b0
        || operand_o !== 32'd0 || op_o !== OP_ADD) begin
      n_fail++;
      $display("FAIL reset_mid got tready=%b valid=%b busy=%b data=%h required all 0",
               rx_tready_o, operand_valid_o, busy_o, operand_o);
    end
    wait_cycles(3);
    rst_n = 1'b1;
    p0 = pops;
    send_hdr(OpcAdd, 16'd12);
    send_word(OP_ADD, 32'h11223344, 1'b1, 1'b0, 1'b1);
    send_word(OP_ADD, 32'hAABBCCDD, 1'b0, 1'b1, 1'b1);
    wait_cycles(3);
    n_checks++;
    if (pops - p0 != 2 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fresh got words=%0d busy=%b required words=2 busy=0", pops - p0, busy_o);
    end
  endtask

  initial begin
    rx_tdata      = 8'd0;
    rx_tvalid     = 1'b0;
    operand_ready = 1'b1;
    hold_v        = 1'b0;
    hold_w        = 36'd0;
    test_reset();
    test_add();
    test_div_back_to_back();
    test_bad_opcode();
    test_div_bad_len();
    test_backpressure();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_parser.md
Name: alu_cmd_parser

Overview:
Receive-side command decoder for the UART ALU path. It consumes the byte stream from uart_rx (AXI-stream, 8-bit). It parses the 4-byte command header: opcode, reserved byte, then a 16-bit little-endian total length. It assembles little-endian 32-bit operands and presents them to the ALU core on a valid/ready word interface, tagged with the opcode and first/last flags. Malformed commands are flagged and their payload is discarded, so the stream stays framed.

Parameters:
MaxLen, 16'd1024, largest legal total length in bytes, header included; larger lengths are an error.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
rx_tdata_i  in  8  byte from uart_rx m_axis_tdata
rx_tvalid_i  in  1  byte valid
rx_tready_o  out  1  byte accepted when rx_tvalid_i & rx_tready_o
op_o  out  2  decoded opcode (alu_pkg::op_e); stable from end of header until the last operand handshake
operand_o  out  32  assembled operand; byte 0 is bits [7:0]
operand_valid_o  out  1  operand available
operand_ready_i  in  1  ALU accepts operand
operand_first_o  out  1  current operand is operand 0 of the command
operand_last_o  out  1  current operand is the final one of the command
err_o  out  1  one-cycle pulse on a rejected header
busy_o  out  1  high whenever state != HDR or the header byte count != 0

Behaviour:
- Reset (async, rst_ni low): state=HDR, all counters 0. Outputs: rx_tready_o=0, operand_valid_o=0, operand_o=0, op_o=OP_ADD, first/last=0, err_o=0, busy_o=0. rx_tready_o may go high from the first clock after deassertion.
- Opcodes: 8'hAD = add, 8'h63 = mul, 8'h5B = div. Header byte 1 is ignored.
- Length L = {byte3, byte2}. A header is valid only if all of the following hold:
  - the opcode is known;
  - L[1:0]==0;
  - 12 <= L <= MaxLen;
  - for div, L==12 exactly.
- Operand count N = (L-4)>>2, counted in a 14-bit register.
- HDR:
  - rx_tready_o=1; accepts 4 bytes.
  - On the 4th accepted byte, validity is evaluated combinationally from the latched bytes plus the incoming byte.
  - Valid header: latch op_o and N, clear the operand index, go to OPND.
  - Invalid header: pulse err_o the next cycle. Drain count = (L>=4) ? L-4 : 0. Go to DRAIN if the count is nonzero, else stay in HDR.
- OPND:
  - rx_tready_o=1; shifts bytes into a 32-bit word, LSB first.
  - On the 4th byte: operand_o is registered, operand_valid_o=1 the next cycle (latency: 1 cycle after the last byte handshake). Go to EMIT.
- EMIT:
  - rx_tready_o=0, so bytes are back-pressured into uart_rx.
  - operand_o, op_o, operand_first_o and operand_last_o are held stable while valid && !ready.
  - operand_first_o = (index==0); operand_last_o = (index==N-1).
  - On handshake: operand_valid_o falls the next cycle. If last, go to HDR; else index++ and go to OPND.
  - Valid/ready handshake: valid never depends on ready.
- DRAIN:
  - rx_tready_o=1; decrements per accepted byte, contents ignored.
  - The count hitting 0 goes to HDR.
  - No operands or valid are emitted.
- Byte handshakes happen only on rx_tvalid_i & rx_tready_o; idle cycles (rx_tvalid_i=0) at any point freeze all counters.
- Length arithmetic is 16-bit unsigned; L-4 is computed only when L>=4, so there is no wrap-around.
- Reset mid-command aborts everything immediately: partial header and partial operand are lost, and valid drops asynchronously.

Decomposition:
- alu_pkg:
  - op_e enum: OP_ADD=2'd0, OP_MUL=2'd1, OP_DIV=2'd2.
  - opcode byte constants: OpcAdd=8'hAD, OpcMul=8'h63, OpcDiv=8'h5B.
  - HdrBytes=4, WordBytes=4, MinLen=12, DivLen=12.
  - state enum: HDR, OPND, EMIT, DRAIN.
  - The future response serializer reuses this package.
- Sub-module: none; a single FSM with shift register and counters. The response framer (result to 4 or 8 bytes) is a separate block, not part of this one.

Test Plan:
- Add, header AD 00 10 00, operands 01000000 02000000 03000000 -> three words 1,2,3:
  - op_o=OP_ADD;
  - first only on word 1, last only on word 3;
  - no err_o.
- Div, header 5B 00 0C 00, operands 64000000 07000000 -> words 100 then 7, op_o=OP_DIV, last on the 2nd word; then a new header is accepted immediately.
- Bad opcode 12 00 0C 00 + 8 bytes -> err_o one pulse, 8 bytes drained, no operand_valid_o. A following valid mul command (63 00 0C 00, 5, 6) emits 5 and 6 correctly.
- Div with L=16 (5B 00 10 00) -> err_o, 12 bytes drained. Also L=0x000D -> err_o, 9 bytes drained.
- Backpressure: operand_ready_i low for 50 cycles during word 2 -> operand_o/flags stable, rx_tready_o=0 throughout; the word is accepted once when ready rises.
- Reset asserted after 2 operand bytes -> all outputs reset, busy_o=0. A fresh add command then decodes correctly with no stale bytes.
